cpu_ctrl_fsm: RTL
=================

// Module: cpu_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit that sits at the other end of the instruction-fetch interface.
//  It drives write_ir, write_pc and pc_s into the fetch stage.
//  It consumes the latched IR together with the fetch-side condition result W_IR_valid.
//  It owns the architectural NZCV flag register, which the fetch stage uses for condition
//  evaluation, and sequences the datapath: ALU, register file and data memory.
// PARAMETERS
//  MEM_LAT   1        data-memory read wait cycles, legal 1..15
//  NZCV_RST  4'b0000  reset value of the NZCV flag register
// PORTS
//  clk         in   1   system clock; FSM and flags update on posedge
//  rst         in   1   reset, asynchronous, active-high
//  IR          in   32  instruction latched by the fetch stage
//  W_IR_valid  in   1   fetch condition passed, sampled in S_FETCH
//  alu_nzcv    in   4   ALU flag result for the current operation
//  write_ir    out  1   IR load strobe to fetch
//  write_pc    out  1   PC load strobe to fetch
//  pc_s        out  2   PC source: 00 = +4, 01 = branch target, 10 = register target, 11 = zero
//  NZCV        out  4   flag register, {N,Z,C,V}
//  alu_op      out  4   = IR[24:21] for data-processing; 4'b0100 (ADD) for address generation
//  alu_src_imm out  1   = IR[25] for data-processing; 1 for load/store
//  rf_we       out  1   register-file write strobe
//  rf_link     out  1   write PC+4 into r14; qualifies rf_we
//  mem_to_reg  out  1   write-back data comes from memory
//  mem_re      out  1   data-memory read
//  mem_we      out  1   data-memory write
//  illegal     out  1   sticky undefined-instruction indication
// BEHAVIOUR
//  - State register: S_IDLE, S_FETCH, S_DECODE, S_EXEC_DP, S_EXEC_MEM, S_MEM_LD, S_MEM_ST,
//    S_WB, S_BRANCH, S_TRAP.
//  - Outputs: decoded combinationally from state and IR; no output is asserted outside the
//    states listed below.
//  - Reset: state = S_IDLE, NZCV = NZCV_RST, wait counter = 0, illegal = 0.
//    All strobes are 0; pc_s = 00.
//  - Reset asserted mid-instruction: the current instruction is abandoned with no strobe
//    glitch. Fetch resets PC in parallel.
//  - S_IDLE: one cycle, then S_FETCH.
//  - S_FETCH: write_ir = 1, write_pc = 1, pc_s = 00.
//    - W_IR_valid = 0: the instruction is squashed. Fetch keeps the old IR and PC has
//      already advanced. Stay in S_FETCH.
//    - W_IR_valid = 1: go to S_DECODE.
//  - S_DECODE: classify IR.
//    - BX: IR[27:4] = 24'h12FFF1 -> S_BRANCH.
//    - B/BL: IR[27:25] = 101 -> S_BRANCH.
//    - Load/store: IR[27:26] = 01 -> S_EXEC_MEM.
//    - Data-processing: IR[27:26] = 00 -> S_EXEC_DP.
//    - Anything else -> undefined.
//  - S_EXEC_DP: rf_we = 1, except for opcodes 1000..1011 (TST/TEQ/CMP/CMN).
//    - NZCV <= alu_nzcv on this clock edge when IR[20] = 1, or always for 1000..1011.
//    - Next state S_FETCH. Total: 3 cycles.
//  - S_EXEC_MEM: address generation. Next S_MEM_LD if IR[20] = 1, else S_MEM_ST.
//  - S_MEM_ST: mem_we = 1 for exactly one cycle, then S_FETCH. Total: 4 cycles.
//  - S_MEM_LD: mem_re = 1.
//    - Stay for MEM_LAT cycles; a 4-bit counter loads on entry and counts down to 0.
//    - Then S_WB.
//  - S_WB: rf_we = 1, mem_to_reg = 1, then S_FETCH. Total load cycles: 4 + MEM_LAT.
//  - S_BRANCH: write_pc = 1, then S_FETCH.
//    - pc_s = 10 for BX, 01 for B/BL.
//    - BL additionally asserts rf_we and rf_link in the same cycle.
//  - Loads/stores and data-processing never write NZCV, except as stated for S_EXEC_DP.
//  - NZCV holds its value in every other state.
// CONFIGURATION
//  CPU_CTRL_ILLEGAL_TRAP_EN
//  - Defined: an undefined instruction goes S_DECODE -> S_TRAP.
//    - S_TRAP: illegal <= 1 (sticky until rst), write_pc = 1, pc_s = 11, so fetch restarts
//      at address 0. Then S_FETCH.
//  - Undefined: an undefined instruction is a NOP (S_DECODE -> S_FETCH).
//    - illegal is tied to 0. S_TRAP is unreachable and may be omitted.
// STRUCTURE
//  - Package cpu_ctrl_pkg holds:
//    - state encodings;
//    - PC_S_INC / PC_S_BR / PC_S_REG / PC_S_ZERO;
//    - DP opcode constants (ADD = 4'b0100, TST..CMN = 4'b1000..4'b1011);
//    - class-match constants (BX pattern, B field, LS field).
//  - Sub-module ctrl_instr_class: combinational IR -> {is_dp, is_ls, is_b, is_bl, is_bx,
//    is_undef, is_cmp, is_load}.
//  - Top level holds the state register, wait counter, NZCV register and output decode.
// TESTING
//  1. Reset, then release: 1 idle cycle, then write_ir = write_pc = 1 with pc_s = 00.
//     NZCV = NZCV_RST.
//  2. IR = 32'hE0910002 (ADDS), alu_nzcv = 4'b0110: S_EXEC_DP asserts rf_we.
//     NZCV becomes 0110; the next S_FETCH occurs 3 cycles after the previous one.
//  3. IR = 32'hE1510002 (CMP), alu_nzcv = 4'b1000: rf_we stays 0, NZCV = 1000.
//     Then W_IR_valid = 0 in S_FETCH: the FSM holds S_FETCH and no other strobes fire.
//  4. IR = 32'hE5912000 (LDR), MEM_LAT = 3: mem_re high for exactly 3 cycles.
//     Then one rf_we + mem_to_reg cycle. STR 32'hE5812000 gives exactly one mem_we pulse.
//  5. BL 32'hEB000004: write_pc = 1 with pc_s = 01, plus rf_we + rf_link.
//     BX 32'hE12FFF1E: pc_s = 10, rf_we = 0.
//  6. IR = 32'hE7F000F0 (undefined):
//     - with CPU_CTRL_ILLEGAL_TRAP_EN: illegal = 1 and pc_s = 11 pulse;
//     - without it: straight back to S_FETCH, illegal = 0.
//     Also assert rst in S_MEM_LD: all strobes drop immediately.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle CPU control unit.
//  - FSM state encodings (plain 4-bit constants for compatibility with older tools).
//  - PC source selects driven to the fetch stage.
//  - Data-processing opcode constants.
//  - Instruction-class match fields.
//  - Packed instruction-class record produced by ctrl_instr_class.
package cpu_ctrl_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_DP  = 4'd3;
  localparam logic [3:0] S_EXEC_MEM = 4'd4;
  localparam logic [3:0] S_MEM_LD   = 4'd5;
  localparam logic [3:0] S_MEM_ST   = 4'd6;
  localparam logic [3:0] S_WB       = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_TRAP     = 4'd9;

  localparam logic [1:0] PC_S_INC  = 2'b00;
  localparam logic [1:0] PC_S_BR   = 2'b01;
  localparam logic [1:0] PC_S_REG  = 2'b10;
  localparam logic [1:0] PC_S_ZERO = 2'b11;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;

  localparam logic [23:0] BX_PATTERN = 24'h12FFF1;  // IR[27:4]
  localparam logic [2:0]  B_FIELD    = 3'b101;      // IR[27:25]
  localparam logic [1:0]  LS_FIELD   = 2'b01;       // IR[27:26]
  localparam logic [1:0]  DP_FIELD   = 2'b00;       // IR[27:26]

  typedef struct packed {
    logic is_dp;
    logic is_ls;
    logic is_b;      // B or BL
    logic is_bl;
    logic is_bx;
    logic is_undef;
    logic is_cmp;    // TST/TEQ/CMP/CMN: flags only, no register write
    logic is_load;
  } instr_class_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control interface between cpu_ctrl_fsm and the fetch stage / datapath.
//  master : the control FSM (consumes IR, W_IR_valid, alu_nzcv; drives strobes and NZCV)
//  slave  : the fetch stage / datapath side
interface cpu_ctrl_fsm_if;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic [3:0]  alu_nzcv;
  logic        write_ir;
  logic        write_pc;
  logic [1:0]  pc_s;
  logic [3:0]  NZCV;
  logic [3:0]  alu_op;
  logic        alu_src_imm;
  logic        rf_we;
  logic        rf_link;
  logic        mem_to_reg;
  logic        mem_re;
  logic        mem_we;
  logic        illegal;

  modport master (
    input  IR, W_IR_valid, alu_nzcv,
    output write_ir, write_pc, pc_s, NZCV, alu_op, alu_src_imm,
           rf_we, rf_link, mem_to_reg, mem_re, mem_we, illegal
  );

  modport slave (
    output IR, W_IR_valid, alu_nzcv,
    input  write_ir, write_pc, pc_s, NZCV, alu_op, alu_src_imm,
           rf_we, rf_link, mem_to_reg, mem_re, mem_we, illegal
  );
endinterface

// File: rtl/cpu_ctrl_fsm_instr_class.sv
// ctrl_instr_class: purely combinational instruction classifier.
//  ir  in  IR[27:4] of the latched instruction (the only bits that affect class)
//  cls out instruction-class record (see cpu_ctrl_pkg::instr_class_t)
// Priority: BX, then B/BL, then load/store, then data-processing, else undefined.
module ctrl_instr_class
  import cpu_ctrl_pkg::*;
(
  input  logic [27:4]  ir,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    if (ir[27:4] == BX_PATTERN) begin
      cls.is_bx = 1'b1;
    end else if (ir[27:25] == B_FIELD) begin
      cls.is_b  = 1'b1;
      cls.is_bl = ir[24];
    end else if (ir[27:26] == LS_FIELD && !(ir[25] && ir[4])) begin
      // Register-offset encodings with bit 4 set are the architecturally
      // undefined hole inside the load/store space (e.g. 0xE7F000F0).
      cls.is_ls = 1'b1;
    end else if (ir[27:26] == DP_FIELD) begin
      cls.is_dp = 1'b1;
    end else begin
      cls.is_undef = 1'b1;
    end
    // Opcodes 1000..1011 share the pattern 10xx.
    cls.is_cmp  = cls.is_dp && (ir[24:23] == 2'b10);
    cls.is_load = cls.is_ls && ir[20];
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control unit behind the instruction-fetch stage.
// Sequences fetch, decode, data-processing, load/store and branch, owns the
// NZCV flag register.
//  clk   in  system clock, posedge
//  rst   in  asynchronous active-high reset
//  bus   cpu_ctrl_fsm_if.master: IR, W_IR_valid, alu_nzcv in; write_ir,
//        write_pc, pc_s, NZCV, alu_op, alu_src_imm, rf_we, rf_link,
//        mem_to_reg, mem_re, mem_we, illegal out
// Parameters: MEM_LAT (1..15 load wait cycles), NZCV_RST (flag reset value).
// Build option: define CPU_CTRL_ILLEGAL_TRAP_EN to trap undefined
// instructions (sticky illegal, restart at address 0); otherwise they are NOPs.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter logic [3:0]  NZCV_RST = 4'b0000
) (
  input logic            clk,
  input logic            rst,
  cpu_ctrl_fsm_if.master bus
);

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  logic [3:0]   state;
  logic [3:0]   state_nxt;
  logic [3:0]   wait_cnt;
  logic [3:0]   nzcv_q;
  instr_class_t cls;
  logic         unused_ir_bits;

  assign unused_ir_bits = ^{bus.IR[31:28], bus.IR[3:0]};

  ctrl_instr_class u_class (
    .ir  (bus.IR[27:4]),
    .cls (cls)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     state_nxt = S_FETCH;
      S_FETCH:    if (bus.W_IR_valid) state_nxt = S_DECODE;
      S_DECODE: begin
        if (cls.is_bx || cls.is_b) state_nxt = S_BRANCH;
        else if (cls.is_ls)        state_nxt = S_EXEC_MEM;
        else if (cls.is_dp)        state_nxt = S_EXEC_DP;
        else
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                                   state_nxt = S_TRAP;
`else
                                   state_nxt = S_FETCH;
`endif
      end
      S_EXEC_DP:  state_nxt = S_FETCH;
      S_EXEC_MEM: state_nxt = cls.is_load ? S_MEM_LD : S_MEM_ST;
      S_MEM_LD:   if (wait_cnt == 4'd0) state_nxt = S_WB;
      S_MEM_ST:   state_nxt = S_FETCH;
      S_WB:       state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_nxt = S_FETCH;
`endif
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Loaded on the way into S_MEM_LD so the state lasts exactly MEM_LAT cycles
  // (it leaves when the count reaches zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (state == S_EXEC_MEM) begin
      wait_cnt <= LAT_LOAD;
    end else if (state == S_MEM_LD && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Flags change only on the edge that leaves S_EXEC_DP, for S-suffixed
  // data-processing or for the compare/test group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_q <= NZCV_RST;
    end else if (state == S_EXEC_DP && (bus.IR[20] || cls.is_cmp)) begin
      nzcv_q <= bus.alu_nzcv;
    end
  end

  assign bus.NZCV = nzcv_q;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  illegal_q <= 1'b0;
    else if (state == S_TRAP) illegal_q <= 1'b1;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  // Outputs are a pure function of state and IR, so an asynchronous reset
  // drops every strobe in the same instant without a glitch cycle.
  always_comb begin
    bus.write_ir    = 1'b0;
    bus.write_pc    = 1'b0;
    bus.pc_s        = PC_S_INC;
    bus.alu_op      = 4'b0000;
    bus.alu_src_imm = 1'b0;
    bus.rf_we       = 1'b0;
    bus.rf_link     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.mem_re      = 1'b0;
    bus.mem_we      = 1'b0;
    case (state)
      S_FETCH: begin
        bus.write_ir = 1'b1;
        bus.write_pc = 1'b1;
      end
      S_EXEC_DP: begin
        bus.alu_op      = bus.IR[24:21];
        bus.alu_src_imm = bus.IR[25];
        bus.rf_we       = !cls.is_cmp;
      end
      // Address generation is held through the access so the memory address
      // stays stable while mem_re / mem_we are asserted.
      S_EXEC_MEM, S_MEM_LD, S_MEM_ST: begin
        bus.alu_op      = OP_ADD;
        bus.alu_src_imm = 1'b1;
        bus.mem_re      = (state == S_MEM_LD);
        bus.mem_we      = (state == S_MEM_ST);
      end
      S_WB: begin
        bus.rf_we      = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        bus.write_pc = 1'b1;
        bus.pc_s     = cls.is_bx ? PC_S_REG : PC_S_BR;
        bus.rf_we    = cls.is_bl;
        bus.rf_link  = cls.is_bl;
      end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        bus.write_pc = 1'b1;
        bus.pc_s     = PC_S_ZERO;
      end
`endif
      default: ;
    endcase
  end

endmodule
